psg_mixer: RTL and testbench
============================

# psg_mixer

Parametrised multi-PSG stereo mixer, the successor to the fixed ABC mixing on the motherboard, where audio_l = A/2 + B/4 and audio_r = C/2 + B/4. It takes the three channel levels of each of CHIPS YM2149 instances: the on-board PSG plus up to three expansion PSGs (PlayCity-style). It accumulates them through one time-multiplexed adder into saturated stereo samples, with selectable stereo mode and per-chip enable. It sits between the PSG instances and the board-level audio_l/audio_r outputs, strobed by the PSG clock enable.

## Interface
- CHIPS, 1, number of PSGs mixed (1..4)
- IN_W, 8, width of each channel level (unsigned)
- OUT_W, 10, width of each output sample (unsigned); IN_W+2 gives lossless output for CHIPS=1
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately
- ce  in  1  sample request strobe, one clk wide
- mode  in  2  stereo mode: 0 mono, 1 ABC, 2 ACB, 3 BAC
- chip_en  in  CHIPS  per-chip enable; a disabled chip contributes 0
- ch_in  in  3*CHIPS*IN_W  channel levels; chip i occupies [(3i+3)*IN_W-1 : 3i*IN_W], ordered A (lowest), B, C
- audio_l  out  OUT_W  left sample
- audio_r  out  OUT_W  right sample
- valid  out  1  one-clk pulse: new samples on audio_l/audio_r
- busy  out  1  mixing in progress; ce is not accepted
- overrun  out  1  one-clk pulse: ce arrived while busy and was dropped

## Operation
- FSM states: IDLE, ACC, OUT.
- IDLE with ce=1:
  - snapshot ch_in, chip_en and mode into holding registers
  - clear acc_l and acc_r; set index k=0; go to ACC
- ACC, one channel per clk:
  - channel k = chip k/3, letter k%3, taken from the snapshot
  - add w_l*level to acc_l and w_r*level to acc_r
  - after k = 3*CHIPS-1, go to OUT; otherwise increment k
- Weights (w_l, w_r) per mode:
  - mono: every channel (1,1)
  - ABC: A (2,0), B (1,1), C (0,2)
  - ACB: A (2,0), C (1,1), B (0,2)
  - BAC: B (2,0), A (1,1), C (0,2)
  - chip with snapshot chip_en=0: (0,0)
- Accumulator width: IN_W+2+clog2(CHIPS); it can never overflow.
- OUT state:
  - audio_l = min(acc_l, 2^OUT_W-1); audio_r likewise
  - valid=1 for this one clk; then go to IDLE
- audio_l/audio_r hold their value between valid pulses; they change only in OUT.
- Changes to ch_in, chip_en or mode after the snapshot have no effect on the sample in progress.
- ce while in ACC or OUT: request dropped, overrun pulses on the next clk, FSM undisturbed.
- ce in IDLE never raises overrun.

## Timing
- Capture edge E0 (IDLE, ce=1). Accumulate edges E1..E(3*CHIPS). Output edge E(3*CHIPS+1) registers audio_l, audio_r and valid=1.
- Latency from ce edge to new samples: 3*CHIPS+1 clk. Minimum accepted ce spacing: 3*CHIPS+2 clk.
- busy is registered:
  - high from after E0 through the OUT cycle
  - low in IDLE
  - busy=0 with ce=1 guarantees acceptance
- Reset values: audio_l=0, audio_r=0, valid=0, busy=0, overrun=0, FSM=IDLE, accumulators=0.
- Reset asserted mid-mix: the sample is discarded and no valid pulse is issued. The first ce after reset deasserts starts a fresh mix.
- Reset and ce together: reset wins; the ce is not captured.
- Outputs carry no combinational path from inputs; every output is a flop.

## Test plan
- CHIPS=1, mode=ABC, A=255, B=255, C=0, ce once:
  - valid exactly 4 clk after the ce edge
  - audio_l=765, audio_r=255
  - busy high for 4 cycles
- CHIPS=1, mode=mono, A=10, B=20, C=30: audio_l=audio_r=60. Same input with mode=ACB: audio_l=50, audio_r=70.
- CHIPS=4, all channels 255, mode=ABC, chip_en=4'b1111:
  - raw acc_l=3060, saturated to audio_l=audio_r=1023 (OUT_W=10)
  - chip_en=4'b0001: outputs 765/765
- CHIPS=2, ce pulses 5 clk apart (minimum is 8):
  - second ce dropped, with an overrun pulse 1 clk later
  - exactly one valid pulse
  - ch_in changed 1 clk after the first ce does not alter the result
- Reset asserted at the 2nd ACC cycle, released 3 clk later:
  - all outputs 0 immediately and asynchronously
  - no valid pulse
  - next ce produces a correct sample with full latency

Source files
------------

// File: rtl/psg_mixer.sv
// Multi-PSG stereo mixer: snapshots up to CHIPS x 3 channel levels on ce and
// accumulates them one channel per clk into saturated left/right samples.
module psg_mixer #(
    parameter int CHIPS = 1,
    parameter int IN_W  = 8,
    parameter int OUT_W = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ce,
    input  logic [1:0]                  mode,
    input  logic [CHIPS-1:0]            chip_en,
    input  logic [3*CHIPS*IN_W-1:0]     ch_in,
    output logic [OUT_W-1:0]            audio_l,
    output logic [OUT_W-1:0]            audio_r,
    output logic                        valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int NCH   = 3 * CHIPS;
    localparam int KW    = $clog2(NCH);
    localparam int CW    = (CHIPS > 1) ? $clog2(CHIPS) : 1;
    localparam int ACC_W = IN_W + 2 + $clog2(CHIPS);
    localparam int SW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [KW-1:0]    K_LAST  = KW'(NCH - 1);
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    state_t state, state_nx;

    logic [3*CHIPS*IN_W-1:0] snap_ch;
    logic [CHIPS-1:0]        snap_en;
    logic [1:0]              snap_mode;
    logic [KW-1:0]           k;
    logic [1:0]              letter;
    logic [CW-1:0]           chip;
    logic [ACC_W-1:0]        acc_l, acc_r;

    logic [IN_W-1:0]         level;
    logic [ACC_W-1:0]        lvl_ext, term_l, term_r;
    logic [1:0]              pos;
    logic [1:0]              w_l, w_r;
    logic [OUT_W-1:0]        sat_l, sat_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ce) state_nx = ACC;
            ACC:     if (k == K_LAST) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // pos: stereo placement of the current letter (0 left, 1 centre, 2 right)
    always_comb begin
        level   = snap_ch[int'(k)*IN_W +: IN_W];
        lvl_ext = ACC_W'(level);
        pos     = 2'd1;
        case (snap_mode)
            2'd1: pos = letter;
            2'd2: pos = (letter == 2'd0) ? 2'd0 : (letter == 2'd2) ? 2'd1 : 2'd2;
            2'd3: pos = (letter == 2'd1) ? 2'd0 : (letter == 2'd0) ? 2'd1 : 2'd2;
            default: pos = 2'd1;
        endcase
        w_l = (pos == 2'd0) ? 2'd2 : (pos == 2'd1) ? 2'd1 : 2'd0;
        w_r = (pos == 2'd2) ? 2'd2 : (pos == 2'd1) ? 2'd1 : 2'd0;
        if (!snap_en[chip]) begin
            w_l = 2'd0;
            w_r = 2'd0;
        end
        term_l = (w_l == 2'd2) ? (lvl_ext << 1) : (w_l == 2'd1) ? lvl_ext : '0;
        term_r = (w_r == 2'd2) ? (lvl_ext << 1) : (w_r == 2'd1) ? lvl_ext : '0;
        sat_l  = (SW'(acc_l) > SW'(OUT_MAX)) ? OUT_MAX : OUT_W'(acc_l);
        sat_r  = (SW'(acc_r) > SW'(OUT_MAX)) ? OUT_MAX : OUT_W'(acc_r);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_ch   <= '0;
            snap_en   <= '0;
            snap_mode <= '0;
            k         <= '0;
            letter    <= '0;
            chip      <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            audio_l   <= '0;
            audio_r   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid   <= (state == OUT);
            busy    <= (state_nx != IDLE);
            overrun <= ce && (state != IDLE);
            case (state)
                IDLE: if (ce) begin
                    snap_ch   <= ch_in;
                    snap_en   <= chip_en;
                    snap_mode <= mode;
                    k         <= '0;
                    letter    <= '0;
                    chip      <= '0;
                    acc_l     <= '0;
                    acc_r     <= '0;
                end
                ACC: begin
                    acc_l <= acc_l + term_l;
                    acc_r <= acc_r + term_r;
                    k     <= k + KW'(1);
                    if (letter == 2'd2) begin
                        letter <= '0;
                        chip   <= chip + CW'(1);
                    end else begin
                        letter <= letter + 2'd1;
                    end
                end
                OUT: begin
                    audio_l <= sat_l;
                    audio_r <= sat_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psg_mixer.sv
// Directed bench for psg_mixer: CHIPS=1, 2 and 4 instances sharing clk/reset.
module tb_psg_mixer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        ce1 = 0, ce2 = 0, ce4 = 0;
    logic [1:0]  mode1 = 0, mode2 = 0, mode4 = 0;
    logic [0:0]  en1 = '1;
    logic [1:0]  en2 = '1;
    logic [3:0]  en4 = '1;
    logic [23:0] ch1 = '0;
    logic [47:0] ch2 = '0;
    logic [95:0] ch4 = '0;
    logic [9:0]  l1, r1, l2, r2, l4, r4;
    logic        v1, b1, o1, v2, b2, o2, v4, b4, o4;

    psg_mixer #(.CHIPS(1), .IN_W(8), .OUT_W(10)) u1 (
        .clk(clk), .reset(reset), .ce(ce1), .mode(mode1), .chip_en(en1), .ch_in(ch1),
        .audio_l(l1), .audio_r(r1), .valid(v1), .busy(b1), .overrun(o1));
    psg_mixer #(.CHIPS(2), .IN_W(8), .OUT_W(10)) u2 (
        .clk(clk), .reset(reset), .ce(ce2), .mode(mode2), .chip_en(en2), .ch_in(ch2),
        .audio_l(l2), .audio_r(r2), .valid(v2), .busy(b2), .overrun(o2));
    psg_mixer #(.CHIPS(4), .IN_W(8), .OUT_W(10)) u4 (
        .clk(clk), .reset(reset), .ce(ce4), .mode(mode4), .chip_en(en4), .ch_in(ch4),
        .audio_l(l4), .audio_r(r4), .valid(v4), .busy(b4), .overrun(o4));

    int sel = 1;
    logic [9:0] sl, sr;
    logic       sv, sb, so;
    always_comb begin
        case (sel)
            1:       begin sl = l1; sr = r1; sv = v1; sb = b1; so = o1; end
            2:       begin sl = l2; sr = r2; sv = v2; sb = b2; so = o2; end
            default: begin sl = l4; sr = r4; sv = v4; sb = b4; so = o4; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_ce(input logic v);
        case (sel)
            1:       ce1 = v;
            2:       ce2 = v;
            default: ce4 = v;
        endcase
    endtask

    // One accepted ce, then wait (bounded) for valid; n=-1 if it never comes.
    task automatic do_mix(output int n, output int nb, output int nov);
        n = -1; nb = 0; nov = 0;
        @(negedge clk); drive_ce(1'b1);
        @(posedge clk); #1; drive_ce(1'b0);
        if (sb) nb++;
        if (so) nov++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (sb) nb++;
            if (so) nov++;
            if (sv) begin n = i; break; end
        end
    endtask

    int n, nb, nov, vcnt, vt, ovc, ovt;
    logic [9:0] lv, rv;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_l1", 32'(l1), 0);
        chk("rst_r1", 32'(r1), 0);
        chk("rst_ctl1", 32'({v1, b1, o1}), 0);
        chk("rst_ctl2", 32'({v2, b2, o2, l2 | r2}), 0);
        chk("rst_ctl4", 32'({v4, b4, o4, l4 | r4}), 0);
        @(negedge clk); reset = 1'b0;

        // CHIPS=1 ABC, A=255 B=255 C=0
        sel = 1; mode1 = 2'd1; en1 = 1'b1; ch1 = {8'd0, 8'd255, 8'd255};
        do_mix(n, nb, nov);
        chk("abc_latency", 32'(n), 4);
        chk("abc_busy_cycles", 32'(nb), 4);
        chk("abc_no_overrun", 32'(nov), 0);
        chk("abc_l", 32'(l1), 765);
        chk("abc_r", 32'(r1), 255);
        @(posedge clk); #1;
        chk("abc_valid_drop", 32'(v1), 0);
        chk("abc_hold_l", 32'(l1), 765);

        // mono then ACB, A=10 B=20 C=30
        mode1 = 2'd0; ch1 = {8'd30, 8'd20, 8'd10};
        do_mix(n, nb, nov);
        chk("mono_l", 32'(l1), 60);
        chk("mono_r", 32'(r1), 60);
        mode1 = 2'd2;
        do_mix(n, nb, nov);
        chk("acb_l", 32'(l1), 50);
        chk("acb_r", 32'(r1), 70);
        mode1 = 2'd3;
        do_mix(n, nb, nov);
        chk("bac_l", 32'(l1), 50);
        chk("bac_r", 32'(r1), 70);

        // CHIPS=4 saturation and per-chip enable
        sel = 4; mode4 = 2'd1; en4 = 4'b1111; ch4 = '1;
        do_mix(n, nb, nov);
        chk("c4_latency", 32'(n), 13);
        chk("c4_sat_l", 32'(l4), 1023);
        chk("c4_sat_r", 32'(r4), 1023);
        en4 = 4'b0001;
        do_mix(n, nb, nov);
        chk("c4_en1_l", 32'(l4), 765);
        chk("c4_en1_r", 32'(r4), 765);

        // CHIPS=2: snapshot isolation, second ce 5 clk later is dropped
        sel = 2; mode2 = 2'd1; en2 = 2'b11;
        ch2 = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        @(negedge clk); ce2 = 1'b1;
        @(posedge clk); #1; ce2 = 1'b0;
        ch2 = '1;
        vcnt = 0; vt = -1; ovc = 0; ovt = -1; lv = '0; rv = '0;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            if (o2) begin ovc++; ovt = t; end
            if (v2) begin vcnt++; vt = t; lv = l2; rv = r2; end
            if (t == 4) ce2 = 1'b1;
            if (t == 5) ce2 = 1'b0;
        end
        chk("c2_valid_count", 32'(vcnt), 1);
        chk("c2_valid_time", 32'(vt), 7);
        chk("c2_overrun_count", 32'(ovc), 1);
        chk("c2_overrun_time", 32'(ovt), 5);
        chk("c2_l", 32'(lv), 17);
        chk("c2_r", 32'(rv), 25);

        // reset during 2nd ACC cycle on CHIPS=1 (outputs hold 50/70 beforehand)
        sel = 1; mode1 = 2'd0; ch1 = {8'd30, 8'd20, 8'd10};
        @(negedge clk); ce1 = 1'b1;
        @(posedge clk); #1; ce1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_l", 32'(l1), 0);
        chk("midrst_r", 32'(r1), 0);
        chk("midrst_busy", 32'(b1), 0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        vcnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (v1) vcnt++;
        end
        chk("midrst_no_valid", 32'(vcnt), 0);
        do_mix(n, nb, nov);
        chk("post_rst_latency", 32'(n), 4);
        chk("post_rst_l", 32'(l1), 60);
        chk("post_rst_r", 32'(r1), 60);

        // reset and ce together: ce must not be captured
        @(negedge clk); reset = 1'b1; ce1 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b0; ce1 = 1'b0;
        @(posedge clk); #1;
        chk("rst_ce_busy", 32'(b1), 0);
        chk("rst_ce_l", 32'(l1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
